iterative_shift_right: RTL

Multi-cycle right-direction shifter for the ARMv7 datapath. It is the counterpart of the combinational left shifter and covers LSR, ASR, ROR and RRX with register-specified amounts. It performs one bit per cycle under a start/done handshake and produces ARM-exact result and carry-out values. It sits beside the ALU operand-2 path and is used when the register-shift form is executed as a multi-cycle operation.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_right_step.sv | 36 +++
 rtl/iterative_shift_right.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the ARMv7 shifter datapath.
// Holds the SHIFT_OP encodings (shared with the combinational left shifter),
// the iterative shifter state enum and the datapath size constants.
package shift_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] SH_LSL = 3'b000;
    localparam logic [2:0] SH_LSR = 3'b010;
    localparam logic [2:0] SH_ASR = 3'b100;
    localparam logic [2:0] SH_ROR = 3'b110;
    localparam logic [2:0] SH_RRX = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One-bit right-shift step for the iterative shifter.
// Ports:
//   data      : current working value
//   op        : latched SHIFT_OP selecting the fill bit
//   cin       : latched CPSR.C, used as the fill for RRX
//   next_data : data shifted right by one with the selected fill
//   carry     : bit shifted out (data[0])
module shift_right_step
    import shift_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] data,
    input  logic [2:0]   op,
    input  logic         cin,
    output logic [W-1:0] next_data,
    output logic         carry
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        case (op)
            SH_LSR:  fill = 1'b0;
            SH_ASR:  fill = data[W-1];
            SH_ROR:  fill = data[0];
            SH_RRX:  fill = cin;
            default: fill = 1'b0;
        endcase
    end

    assign next_data = {fill, data[W-1:1]};
    assign carry     = data[0];

endmodule

// File: rtl/iterative_shift_right.sv
// Multi-cycle right shifter (LSR/ASR/ROR/RRX), one bit per cycle.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   Start            : request strobe, accepted while Busy=0
//   SHIFT_OP         : operation code (unknown codes pass the operand through)
//   Shift_Data       : operand, sampled on accepted Start
//   Shift_Num        : shift amount, sampled on accepted Start
//   Carry_In         : CPSR.C, sampled on accepted Start
//   Busy             : high while shifting
//   Done             : one-cycle completion pulse
//   Shift_Out        : result, held until the next operation steps
//   Shift_Carry_Out  : shifter carry-out, held with Shift_Out
//
// state    | meaning
// ST_IDLE  | waiting for Start
// ST_SHIFT | one shift step per cycle until count reaches 0
// ST_DONE  | Done pulse; a new Start is accepted here
module iterative_shift_right
    import shift_pkg::*;
#(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int CNT_W = shift_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       SHIFT_OP,
    input  logic [WIDTH-1:0] Shift_Data,
    input  logic [7:0]       Shift_Num,
    input  logic             Carry_In,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Shift_Out,
    output logic             Shift_Carry_Out
);

    state_t state_q, state_d;

    logic [WIDTH-1:0] data_q;
    logic [2:0]       op_q;
    logic             cin_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] out_q;
    logic             cout_q;

    logic [CNT_W-1:0] count_init;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    // Iteration count from the requested amount. LSR needs a 33rd step to
    // push out a zero carry for amounts above 32; ASR saturates at 32 since
    // further steps only repeat the sign bit; ROR wraps modulo 32 with a
    // full 32-step rotation for non-zero multiples of 32.
    always_comb begin
        count_init = '0;
        case (SHIFT_OP)
            SH_LSR: begin
                if (Shift_Num == 8'd0)
                    count_init = '0;
                else if (Shift_Num <= 8'd32)
                    count_init = CNT_W'(Shift_Num);
                else
                    count_init = CNT_W'(33);
            end
            SH_ASR: begin
                if (Shift_Num <= 8'd32)
                    count_init = CNT_W'(Shift_Num);
                else
                    count_init = CNT_W'(32);
            end
            SH_ROR: begin
                if (Shift_Num == 8'd0)
                    count_init = '0;
                else if (Shift_Num[4:0] == 5'd0)
                    count_init = CNT_W'(32);
                else
                    count_init = CNT_W'(Shift_Num[4:0]);
            end
            SH_RRX:  count_init = CNT_W'(1);
            default: count_init = '0;
        endcase
    end

    shift_right_step #(
        .W (WIDTH)
    ) u_step (
        .data      (data_q),
        .op        (op_q),
        .cin       (cin_q),
        .next_data (step_data),
        .carry     (step_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    load    = 1'b1;
                    state_d = (count_init != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                step = 1'b1;
                if (count_q == CNT_W'(1))
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs follow the working register only while stepping, so the
    // previous result stays visible until the next operation's first step.
    // Zero-count requests publish the operand and Carry_In directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            op_q    <= SH_LSL;
            cin_q   <= 1'b0;
            count_q <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
        end else if (load) begin
            data_q  <= Shift_Data;
            op_q    <= SHIFT_OP;
            cin_q   <= Carry_In;
            count_q <= count_init;
            if (count_init == '0) begin
                out_q  <= Shift_Data;
                cout_q <= Carry_In;
            end
        end else if (step) begin
            data_q  <= step_data;
            out_q   <= step_data;
            cout_q  <= step_carry;
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign Busy            = (state_q == ST_SHIFT);
    assign Done            = (state_q == ST_DONE);
    assign Shift_Out       = out_q;
    assign Shift_Carry_Out = cout_q;

endmodule
